// File: rtl/draw_pkg.sv
// Shared constants and types for the frame draw scheduler and the VGA input mux.
package draw_pkg;

    // Number of draw engines feeding the mux; the select width caps this at 16.
    localparam int unsigned NUM_LAYERS = 12;
    localparam int unsigned SEL_W      = 4;

    // Layer 0 erases the frame, so it must always paint first.
    localparam logic [SEL_W-1:0] LAYER_BG = '0;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StNext,
        StFinish
    } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// Frame-tick, engine handshake and status bundle between the scheduler and its environment.
interface draw_scheduler_if #(
    parameter int unsigned NUM_LAYERS = draw_pkg::NUM_LAYERS
);
    import draw_pkg::*;

    logic                  i_frame_tick;
    logic [NUM_LAYERS-1:0] i_enable_mask;
    logic [NUM_LAYERS-1:0] i_done;
    logic                  i_clear_flags;
    logic [NUM_LAYERS-1:0] o_start;
    logic [SEL_W-1:0]      o_select;
    logic                  o_busy;
    logic                  o_frame_done;
    logic                  o_overrun;
    logic                  o_timeout;

    modport master (
        input  i_frame_tick, i_enable_mask, i_done, i_clear_flags,
        output o_start, o_select, o_busy, o_frame_done, o_overrun, o_timeout
    );

    modport slave (
        output i_frame_tick, i_enable_mask, i_done, i_clear_flags,
        input  o_start, o_select, o_busy, o_frame_done, o_overrun, o_timeout
    );

endinterface

// File: rtl/draw_scheduler_next_layer_finder.sv
// Priority search for the lowest enabled layer strictly above the current index,
// or the lowest enabled layer overall when starting a frame.
module next_layer_finder
    import draw_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = draw_pkg::NUM_LAYERS
) (
    input  logic [NUM_LAYERS-1:0] i_en,
    input  logic [SEL_W-1:0]      i_idx,
    input  logic                  i_from_start,
    output logic [SEL_W-1:0]      o_next_idx,
    output logic                  o_found
);

    // Walk downwards so the lowest qualifying index is the last one written.
    always_comb begin
        o_next_idx = '0;
        o_found    = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i_en[i] && (i_from_start || (i > int'(i_idx)))) begin
                o_next_idx = SEL_W'(i);
                o_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Frame-level sequencer: on each frame tick, launches the enabled draw engines one
// at a time in index order and steers the VGA mux select to the active engine.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned TW             = 15
) (
    input logic             clock,
    input logic             reset,
    draw_scheduler_if.master bus
);

    state_t                r_state;
    logic [SEL_W-1:0]      r_idx;
    logic [NUM_LAYERS-1:0] r_en;
    logic [TW-1:0]         r_timer;
    logic [NUM_LAYERS-1:0] r_start;
    logic [SEL_W-1:0]      r_select;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_overrun;
    logic                  r_timeout;

    state_t                w_state_d;
    logic [SEL_W-1:0]      w_idx_d;
    logic [NUM_LAYERS-1:0] w_en_d;
    logic [TW-1:0]         w_timer_d;
    logic [NUM_LAYERS-1:0] w_start_d;
    logic [SEL_W-1:0]      w_select_d;
    logic                  w_busy_d;
    logic                  w_frame_done_d;
    logic                  w_overrun_d;
    logic                  w_timeout_d;
    logic                  w_set_timeout;
    logic                  w_set_overrun;

    logic [NUM_LAYERS-1:0] w_find_en;
    logic                  w_find_from_start;
    logic [SEL_W-1:0]      w_next_idx;
    logic                  w_found;

    // In IDLE the search runs on the live mask from "below index 0"; otherwise on en_q above idx.
    assign w_find_from_start = (r_state == StIdle);
    assign w_find_en         = (r_state == StIdle) ? bus.i_enable_mask : r_en;

    next_layer_finder #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_finder (
        .i_en         (w_find_en),
        .i_idx        (r_idx),
        .i_from_start (w_find_from_start),
        .o_next_idx   (w_next_idx),
        .o_found      (w_found)
    );

    // Next-state logic; outputs are derived from the next state so they stay registered.
    always_comb begin
        w_state_d     = r_state;
        w_idx_d       = r_idx;
        w_en_d        = r_en;
        w_timer_d     = r_timer;
        w_set_timeout = 1'b0;
        w_set_overrun = bus.i_frame_tick && (r_state != StIdle);

        unique case (r_state)
            StIdle: begin
                if (bus.i_frame_tick) begin
                    if (w_found) begin
                        w_en_d    = bus.i_enable_mask;
                        w_idx_d   = w_next_idx;
                        w_state_d = StLaunch;
                    end else begin
                        w_state_d = StFinish;
                    end
                end
            end
            StLaunch: begin
                w_timer_d = '0;
                w_state_d = StWait;
            end
            StWait: begin
                w_timer_d = r_timer + TW'(1);
                if (bus.i_done[r_idx]) begin
                    w_state_d = StNext;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_set_timeout = 1'b1;
                    w_state_d     = StNext;
                end
            end
            StNext: begin
                if (w_found) begin
                    w_idx_d   = w_next_idx;
                    w_state_d = StLaunch;
                end else begin
                    w_state_d = StFinish;
                end
            end
            StFinish: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_start_d = '0;
        if (w_state_d == StLaunch) begin
            w_start_d[w_idx_d] = 1'b1;
        end
        // Select only moves on a launch so the mux never glitches between engines.
        w_select_d     = (w_state_d == StLaunch) ? w_idx_d : r_select;
        w_busy_d       = (w_state_d != StIdle);
        w_frame_done_d = (w_state_d == StFinish);

        // A set event in the same cycle as clear_flags wins.
        w_overrun_d = w_set_overrun ? 1'b1 : (bus.i_clear_flags ? 1'b0 : r_overrun);
        w_timeout_d = w_set_timeout ? 1'b1 : (bus.i_clear_flags ? 1'b0 : r_timeout);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_idx        <= LAYER_BG;
            r_en         <= '0;
            r_timer      <= '0;
            r_start      <= '0;
            r_select     <= LAYER_BG;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_en         <= w_en_d;
            r_timer      <= w_timer_d;
            r_start      <= w_start_d;
            r_select     <= w_select_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_frame_done_d;
            r_overrun    <= w_overrun_d;
            r_timeout    <= w_timeout_d;
        end
    end

    assign bus.o_start      = r_start;
    assign bus.o_select     = r_select;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_overrun    = r_overrun;
    assign bus.o_timeout    = r_timeout;

endmodule
